// File: rtl/kgp_risc_pkg.sv
// Shared KGP-RISC definitions: pc_control codes, reset vector, flag bit indices,
// and the branch offset helper. Imported by pc_sequencer and the control unit.
package kgp_risc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PCC_W  = 4;
  localparam int unsigned IMM_W  = 26;
  localparam int unsigned FLAG_W = 4;

  // Next-PC codes driven by the control unit
  localparam logic [PCC_W-1:0] PCC_SEQ  = 4'h0;
  localparam logic [PCC_W-1:0] PCC_B    = 4'h1;
  localparam logic [PCC_W-1:0] PCC_BR   = 4'h2;
  localparam logic [PCC_W-1:0] PCC_BZ   = 4'h3;
  localparam logic [PCC_W-1:0] PCC_BNZ  = 4'h4;
  localparam logic [PCC_W-1:0] PCC_BC   = 4'h5;
  localparam logic [PCC_W-1:0] PCC_BNC  = 4'h6;
  localparam logic [PCC_W-1:0] PCC_BS   = 4'h7;
  localparam logic [PCC_W-1:0] PCC_BNS  = 4'h8;
  localparam logic [PCC_W-1:0] PCC_BV   = 4'h9;
  localparam logic [PCC_W-1:0] PCC_BNV  = 4'hA;
  localparam logic [PCC_W-1:0] PCC_CALL = 4'hB;
  localparam logic [PCC_W-1:0] PCC_RET  = 4'hC;

  localparam logic [XLEN-1:0] PC_RESET_VEC = 32'h0000_0000;

  // Bit positions within the packed flag vector
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_S = 2;
  localparam int unsigned FLAG_V = 3;

  // Sign-extended word offset in bytes
  function automatic logic [XLEN-1:0] br_offset(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry; pops on an empty stack are ignored. Entries are never cleared.
// Ports: clk, rst (sync, active-high), push, pop, wdata -> rdata (top of
// stack), empty, full.
module return_addr_stack #(
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q;   // next free slot; wraps naturally (power-of-2 depth)
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  top_idx;

  assign top_idx = ptr_q - PTR_W'(1);
  assign rdata   = mem_q[top_idx];
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));

  // Pointer and occupancy; count saturates so the oldest entry is silently lost
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      ptr_q <= ptr_q + PTR_W'(1);
      if (!full) cnt_q <= cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Storage is not reset; validity is tracked by cnt_q alone
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[ptr_q] <= wdata;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, status flags and return-address stack for KGP-RISC.
// Ports: clk, rst (sync, active-high), pc_en (0 = stall), pc_control (next-PC
// code), jump_imm (signed word offset), reg_target (BR target), flag_wren and
// alu_* (flag load) -> pc, pc_plus4 (combinational), z/carry/sign/overflow
// flags, ras_empty, ras_full, ras_underflow (one-cycle pulse).
// Build option PC_ALIGN_CHECK_EN adds sticky output misalign: an unaligned
// next PC is refused (pc and stack hold).
module pc_sequencer
  import kgp_risc_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic [3:0]  pc_control,
  input  logic [25:0] jump_imm,
  input  logic [31:0] reg_target,
  input  logic        flag_wren,
  input  logic        alu_z,
  input  logic        alu_carry,
  input  logic        alu_sign,
  input  logic        alu_overflow,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        zflag,
  output logic        carryflag,
  output logic        signflag,
  output logic        overflowflag,
  output logic        ras_empty,
  output logic        ras_full,
`ifdef PC_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic        ras_underflow
);

  logic [XLEN-1:0]   pc_q, pc_d, br_tgt, ras_rdata;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              under_q, under_d;
  logic              push_req, pop_req, advance;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + br_offset(jump_imm);

  // Next-PC select; conditional codes arrive already resolved as taken
  always_comb begin
    pc_d     = pc_plus4;
    push_req = 1'b0;
    pop_req  = 1'b0;
    under_d  = 1'b0;
    case (pc_control)
      PCC_B, PCC_BZ, PCC_BNZ, PCC_BC, PCC_BNC,
      PCC_BS, PCC_BNS, PCC_BV, PCC_BNV: pc_d = br_tgt;
      PCC_BR:   pc_d = reg_target;
      PCC_CALL: begin
        pc_d     = br_tgt;
        push_req = 1'b1;
      end
      PCC_RET: begin
        if (!ras_empty) begin
          pc_d    = ras_rdata;
          pop_req = 1'b1;
        end else begin
          under_d = 1'b1;
        end
      end
      default: pc_d = pc_plus4;
    endcase
  end

  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_Z] = alu_z;
    flags_d[FLAG_C] = alu_carry;
    flags_d[FLAG_S] = alu_sign;
    flags_d[FLAG_V] = alu_overflow;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_hit;
  // Only BR and RET can produce low bits; br_tgt is word aligned by construction
  assign misalign_hit = pc_en && (pc_d[1:0] != 2'b00);
  assign advance      = pc_en && !misalign_hit;
  assign misalign     = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_q | misalign_hit;
  end
`else
  assign advance = pc_en;
`endif

  // Flags load independently of pc_en so a stalled pipe still records ALU status
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      flags_q <= '0;
      under_q <= 1'b0;
    end else begin
      if (advance)   pc_q    <= pc_d;
      if (flag_wren) flags_q <= flags_d;
      under_q <= advance & under_d;
    end
  end

  return_addr_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .DATA_W    (XLEN)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (advance & push_req),
    .pop   (advance & pop_req),
    .wdata (pc_plus4),
    .rdata (ras_rdata),
    .empty (ras_empty),
    .full  (ras_full)
  );

  assign pc            = pc_q;
  assign zflag         = flags_q[FLAG_Z];
  assign carryflag     = flags_q[FLAG_C];
  assign signflag      = flags_q[FLAG_S];
  assign overflowflag  = flags_q[FLAG_V];
  assign ras_underflow = under_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expected PCs are queued when a cycle is
// driven and popped for comparison once the edge has been taken.
module tb_pc_sequencer;
  import kgp_risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_en = 1'b0;
  logic [3:0]  pc_control = 4'h0;
  logic [25:0] jump_imm = '0;
  logic [31:0] reg_target = '0;
  logic        flag_wren = 1'b0;
  logic        alu_z = 1'b0, alu_carry = 1'b0, alu_sign = 1'b0, alu_overflow = 1'b0;
  logic [31:0] pc, pc_plus4;
  logic        zflag, carryflag, signflag, overflowflag;
  logic        ras_empty, ras_full, ras_underflow;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_stack[$];

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .pc_en         (pc_en),
    .pc_control    (pc_control),
    .jump_imm      (jump_imm),
    .reg_target    (reg_target),
    .flag_wren     (flag_wren),
    .alu_z         (alu_z),
    .alu_carry     (alu_carry),
    .alu_sign      (alu_sign),
    .alu_overflow  (alu_overflow),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .zflag         (zflag),
    .carryflag     (carryflag),
    .signflag      (signflag),
    .overflowflag  (overflowflag),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
`ifdef PC_ALIGN_CHECK_EN
    .misalign      (misalign),
`endif
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and settle just after the rising edge
  task automatic cycle(input logic [3:0] code, input logic en,
                       input logic [25:0] imm, input logic [31:0] rt);
    pc_control = code;
    pc_en      = en;
    jump_imm   = imm;
    reg_target = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst = 1'b1;
    cycle(PCC_CALL, 1'b1, 26'd3, 32'h0);
    cycle(PCC_RET, 1'b1, 26'd0, 32'h0);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if ({zflag, carryflag, signflag, overflowflag} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got %b expected 0000", {zflag, carryflag, signflag, overflowflag}); end
    checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_underflow !== 1'b0) begin errors++;
      $display("FAIL reset_ras: got empty=%b full=%b uf=%b expected 1 0 0", ras_empty, ras_full, ras_underflow); end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(32'(4 * i));
      cycle(PCC_SEQ, 1'b1, 26'd0, 32'h0);
      e = exp_q.pop_front();
      checks++; if (pc !== e) begin errors++; $display("FAIL reset_step%0d: got %h expected %h", i, pc, e); end
    end
  endtask

  task automatic test_branch();
    logic [3:0]  codes [6];
    logic [25:0] imms  [6];
    logic [31:0] rts   [6];
    logic [31:0] exps  [6];
    logic [31:0] e;
    codes = '{PCC_BR, PCC_B, PCC_BR, PCC_B, PCC_BNV, 4'hD};
    imms  = '{26'd0, 26'h3FFFFFE, 26'd0, 26'd5, 26'd5, 26'd9};
    rts   = '{32'h40, 32'h0, 32'h40, 32'h0, 32'h0, 32'h0};
    exps  = '{32'h40, 32'h3C, 32'h40, 32'h58, 32'h70, 32'h74};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exps[i]);
      cycle(codes[i], 1'b1, imms[i], rts[i]);
      e = exp_q.pop_front();
      checks++; if (pc !== e) begin errors++; $display("FAIL branch%0d: got %h expected %h", i, pc, e); end
    end
  endtask

  task automatic test_call_ret();
    logic [31:0] e;
    exp_q.push_back(32'h100);
    cycle(PCC_BR, 1'b1, 26'd0, 32'h100);
    e = exp_q.pop_front();
    checks++; if (pc !== e) begin errors++; $display("FAIL call_setup: got %h expected %h", pc, e); end
    exp_q.push_back(32'h144);
    cycle(PCC_CALL, 1'b1, 26'h10, 32'h0);
    e = exp_q.pop_front();
    checks++; if (pc !== e || ras_empty !== 1'b0) begin errors++;
      $display("FAIL call: got pc=%h empty=%b expected %h 0", pc, ras_empty, e); end
    exp_q.push_back(32'h104);
    cycle(PCC_RET, 1'b1, 26'h0, 32'h0);
    e = exp_q.pop_front();
    checks++; if (pc !== e || ras_empty !== 1'b1) begin errors++;
      $display("FAIL ret: got pc=%h empty=%b expected %h 1", pc, ras_empty, e); end
  endtask

  task automatic test_ras_boundary();
    logic [31:0] e, cur;
    cycle(PCC_BR, 1'b1, 26'd0, 32'h200);
    cur = 32'h200;
    model_stack.delete();
    for (int i = 0; i < 9; i++) begin
      model_stack.push_back(cur + 32'd4);
      if (model_stack.size() > 8) void'(model_stack.pop_front());
      cur = cur + 32'd8;
      exp_q.push_back(cur);
      cycle(PCC_CALL, 1'b1, 26'd1, 32'h0);
      e = exp_q.pop_front();
      checks++; if (pc !== e) begin errors++; $display("FAIL call_chain%0d: got %h expected %h", i, pc, e); end
    end
    checks++; if (ras_full !== 1'b1) begin errors++; $display("FAIL ras_full: got %b expected 1", ras_full); end
    for (int i = 0; i < 8; i++) begin
      cur = model_stack.pop_back();
      exp_q.push_back(cur);
      cycle(PCC_RET, 1'b1, 26'd0, 32'h0);
      e = exp_q.pop_front();
      checks++; if (pc !== e || ras_underflow !== 1'b0) begin errors++;
        $display("FAIL ret_chain%0d: got pc=%h uf=%b expected %h 0", i, pc, ras_underflow, e); end
    end
    checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++;
      $display("FAIL ras_drained: got empty=%b full=%b expected 1 0", ras_empty, ras_full); end
    cur = cur + 32'd4;
    exp_q.push_back(cur);
    cycle(PCC_RET, 1'b1, 26'd0, 32'h0);
    e = exp_q.pop_front();
    checks++; if (pc !== e || ras_underflow !== 1'b1) begin errors++;
      $display("FAIL underflow: got pc=%h uf=%b expected %h 1", pc, ras_underflow, e); end
    cur = cur + 32'd4;
    cycle(PCC_SEQ, 1'b1, 26'd0, 32'h0);
    checks++; if (pc !== cur || ras_underflow !== 1'b0) begin errors++;
      $display("FAIL underflow_pulse: got pc=%h uf=%b expected %h 0", pc, ras_underflow, cur); end
    cycle(PCC_RET, 1'b0, 26'd0, 32'h0);
    checks++; if (pc !== cur || ras_underflow !== 1'b0) begin errors++;
      $display("FAIL stalled_ret: got pc=%h uf=%b expected %h 0", pc, ras_underflow, cur); end
  endtask

  task automatic test_stall_flags();
    logic [31:0] cur;
    cur = pc;
    flag_wren = 1'b1; alu_z = 1'b1; alu_carry = 1'b1; alu_sign = 1'b0; alu_overflow = 1'b0;
    cycle(PCC_B, 1'b0, 26'd5, 32'h0);
    flag_wren = 1'b0;
    checks++; if (pc !== cur) begin errors++; $display("FAIL stall_pc: got %h expected %h", pc, cur); end
    checks++; if ({zflag, carryflag, signflag, overflowflag} !== 4'b1100) begin errors++;
      $display("FAIL stall_flags: got %b expected 1100", {zflag, carryflag, signflag, overflowflag}); end
    alu_z = 1'b0; alu_carry = 1'b0; alu_sign = 1'b1; alu_overflow = 1'b1;
    cycle(PCC_SEQ, 1'b0, 26'd0, 32'h0);
    checks++; if ({zflag, carryflag, signflag, overflowflag} !== 4'b1100 || pc !== cur) begin errors++;
      $display("FAIL flag_hold: got %b pc=%h expected 1100 %h", {zflag, carryflag, signflag, overflowflag}, pc, cur); end
    flag_wren = 1'b1;
    cycle(PCC_SEQ, 1'b1, 26'd0, 32'h0);
    flag_wren = 1'b0;
    checks++; if ({zflag, carryflag, signflag, overflowflag} !== 4'b0011 || pc !== cur + 32'd4) begin errors++;
      $display("FAIL flag_load: got %b pc=%h expected 0011 %h", {zflag, carryflag, signflag, overflowflag}, pc, cur + 32'd4); end
  endtask

  task automatic test_wrap_br();
    logic [31:0] e;
    exp_q.push_back(32'hFFFF_FFFC);
    cycle(PCC_BR, 1'b1, 26'd0, 32'hFFFF_FFFC);
    e = exp_q.pop_front();
    checks++; if (pc !== e || pc_plus4 !== 32'h0) begin errors++;
      $display("FAIL wrap_setup: got pc=%h p4=%h expected %h 00000000", pc, pc_plus4, e); end
    exp_q.push_back(32'h0);
    cycle(PCC_SEQ, 1'b1, 26'd0, 32'h0);
    e = exp_q.pop_front();
    checks++; if (pc !== e) begin errors++; $display("FAIL wrap: got %h expected %h", pc, e); end
    cycle(PCC_BR, 1'b1, 26'd0, 32'h100);
`ifdef PC_ALIGN_CHECK_EN
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_idle: got %b expected 0", misalign); end
    cycle(PCC_BR, 1'b1, 26'd0, 32'h1002);
    checks++; if (pc !== 32'h100 || misalign !== 1'b1) begin errors++;
      $display("FAIL misalign: got pc=%h mis=%b expected 00000100 1", pc, misalign); end
    cycle(PCC_SEQ, 1'b1, 26'd0, 32'h0);
    checks++; if (pc !== 32'h104 || misalign !== 1'b1) begin errors++;
      $display("FAIL misalign_sticky: got pc=%h mis=%b expected 00000104 1", pc, misalign); end
`else
    cycle(PCC_BR, 1'b1, 26'd0, 32'h1002);
    checks++; if (pc !== 32'h1002) begin errors++; $display("FAIL br_unaligned: got %h expected 00001002", pc); end
`endif
  endtask

  task automatic test_reset_mid_op();
    cycle(PCC_BR, 1'b1, 26'd0, 32'h300);
    cycle(PCC_CALL, 1'b1, 26'd2, 32'h0);
    cycle(PCC_CALL, 1'b1, 26'd2, 32'h0);
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL mid_setup: got empty=%b expected 0", ras_empty); end
    rst = 1'b1;
    cycle(PCC_RET, 1'b1, 26'd0, 32'h0);
    rst = 1'b0;
    checks++; if (pc !== 32'h0 || ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin errors++;
      $display("FAIL mid_reset: got pc=%h empty=%b uf=%b expected 00000000 1 0", pc, ras_empty, ras_underflow); end
    checks++; if ({zflag, carryflag, signflag, overflowflag} !== 4'b0) begin errors++;
      $display("FAIL mid_reset_flags: got %b expected 0000", {zflag, carryflag, signflag, overflowflag}); end
    cycle(PCC_RET, 1'b1, 26'd0, 32'h0);
    checks++; if (pc !== 32'h4 || ras_underflow !== 1'b1) begin errors++;
      $display("FAIL post_reset_ret: got pc=%h uf=%b expected 00000004 1", pc, ras_underflow); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_call_ret();
    test_ras_boundary();
    test_stall_flags();
    test_wrap_br();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Holds the architectural program counter and the processor status flags.
- Flag outputs feed the control unit's branch decision (upstream). The control unit's 4-bit pc_control code drives next-PC selection here (downstream).
- Contains a small return-address stack (RAS) for CALL/RET.
- Output pc drives instruction memory address.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value after reset.
- RAS_DEPTH, 8, return-address stack entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_en  in  1  advance enable; 0 = stall (PC and RAS hold)
- pc_control  in  4  next-PC code from control unit
- jump_imm  in  26  signed word offset from instruction[25:0]
- reg_target  in  32  register-sourced target (BR)
- flag_wren  in  1  latch ALU flags this cycle
- alu_z, alu_carry, alu_sign, alu_overflow  in  1 each  ALU status
- pc  out  32  current PC
- pc_plus4  out  32  pc+4, combinational
- zflag, carryflag, signflag, overflowflag  out  1 each  registered flags
- ras_empty  out  1  stack empty
- ras_full  out  1  stack full
- ras_underflow  out  1  one-cycle pulse: RET on empty stack

Behaviour:
- Reset (rst=1 at clock edge) has priority over everything:
  - pc=RESET_VEC.
  - All flags 0.
  - RAS pointer and count 0: ras_empty=1, ras_full=0.
  - ras_underflow=0.
- Arithmetic:
  - pc_plus4 = pc+32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - br_tgt = pc_plus4 + (sign_ext32(jump_imm)<<2), modulo 2^32.
- Next-PC selection: applied only when pc_en=1. Latency is one cycle: code sampled at edge N gives pc at N+1.
  - 0000: pc_plus4.
  - 0001 (B): br_tgt.
  - 0010 (BR): reg_target.
  - 0011-1010: taken conditional branches, already resolved by the control unit; target is br_tgt.
  - 1011 (CALL): push pc_plus4, then pc=br_tgt.
  - 1100 (RET): pop top-of-stack into pc. If empty: pc=pc_plus4, ras_underflow=1 for one cycle, stack unchanged.
  - 1101-1111: treated as 0000.
- pc_en=0:
  - pc, RAS contents and pointers hold.
  - ras_underflow=0.
  - pc_control is ignored.
- RAS: circular LIFO, RAS_DEPTH entries.
  - CALL when full: overwrites the oldest entry. Pointer wraps, count saturates at RAS_DEPTH, ras_full stays 1.
  - Pop decrements count. Entries are never cleared.
  - ras_empty = (count==0); ras_full = (count==RAS_DEPTH).
- Flags:
  - On an edge with flag_wren=1, all four flags load from the alu_* inputs.
  - Flag loading is independent of pc_en; flags update during a stall.
  - With flag_wren=0, flags hold.
- Same-cycle use: a branch and a flag write in the same cycle resolve against the old flags, because the control unit sees the registered values.
- Reset mid-operation: a pending CALL or RET is discarded and the stack is emptied.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign (1 bit, reset 0).
  - If the selected next PC has bits[1:0]!=0 and pc_en=1: pc holds, no RAS push/pop occurs, and misalign is set sticky until rst.
  - br_tgt is always aligned, so only BR and RET can trigger it.
- Undefined: no misalign port. reg_target is used as-is, low bits included.

Decomposition:
- Shared package kgp_risc_pkg:
  - pc_control code constants: PCC_SEQ, PCC_B, PCC_BR, PCC_BZ…PCC_BNV, PCC_CALL, PCC_RET.
  - RESET_VEC default.
  - Flag bit-index constants.
  - The control unit imports the same constants.
- One sub-module: return_addr_stack.
  - Inputs: push, pop, wdata.
  - Outputs: rdata, empty, full.
  - Parameterised by RAS_DEPTH.

Test Plan:
- Reset: rst=1 for 2 cycles -> pc=0, all flags 0, ras_empty=1; release with pc_control=0, pc_en=1 -> pc steps 4, 8, 12.
- Immediate branch: at pc=0x40, code 0001, jump_imm=26'h3FFFFFE (-2) -> pc=0x3C; at pc=0x40 with jump_imm=5 -> pc=0x58.
- Call/return: at pc=0x100, CALL with imm=0x10 -> pc=0x144 and ras_empty=0; next cycle RET -> pc=0x104, ras_empty=1.
- RAS boundaries:
  - 9 CALLs with RAS_DEPTH=8 -> ras_full=1; 8 RETs return to the 9th…2nd return addresses.
  - A 9th RET -> ras_underflow pulses for 1 cycle and pc=pc_plus4.
- Stall and flags: pc_en=0 with code 0001 -> pc holds; same cycle flag_wren=1 with alu_z=1, alu_carry=1 -> zflag=1 and carryflag=1 next cycle.
- Wrap and BR:
  - Force pc=0xFFFF_FFFC via BR with reg_target=0xFFFF_FFFC, then code 0 -> pc=0.
  - With PC_ALIGN_CHECK_EN, BR to 0x1002 -> pc holds and misalign=1.
